dm_lsu: RTL and testbench
=========================

DM_LSU -- requirements
Module: dm_lsu

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid, input, 1 bit: a memory request is present.
REQ-004 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-005 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load (MemWrite).
REQ-006 SHALL have port req_dmtype, input, 3 bits: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-009 SHALL have port resp_valid, output, 1 bit: response present.
REQ-010 SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-011 SHALL have port resp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-012 SHALL have port resp_err, output, 1 bit: the request was rejected.
REQ-013 SHALL have ports mem_en (output, 1), mem_we (output, 1), mem_addr (output, 30: word address = addr[31:2]), mem_wdata (output, 32), mem_rdata (input, 32): single-port synchronous word RAM.
REQ-014 SHALL present mem_rdata from the RAM one cycle after mem_en=1 with mem_we=0.

Function
REQ-015 SHALL implement states IDLE, RD, CAP, WR, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE; a handshake is req_valid&req_ready, and it registers req_*.
REQ-017 SHALL, on a handshake, go to WR for a word store, to RD for any load or sub-word store, and to RESP with err=1 for an illegal dmtype (101-111), with no RAM access in the error case.
REQ-018 SHALL, in RD, drive mem_en=1, mem_we=0 and go to CAP.
REQ-019 SHALL, in CAP, do one of the following: for a load, select the lane, extend it, register resp_rdata and go to RESP; for a sub-word store, merge the store lane into the read word and go to WR.
REQ-020 SHALL, in WR, drive mem_en=1, mem_we=1 and mem_wdata (full word or merged word), then go to RESP.
REQ-021 SHALL assert resp_valid only in RESP and hold resp_rdata and resp_err stable until resp_valid&resp_ready; on that handshake it returns to IDLE, so there is no same-cycle re-accept.
REQ-022 SHALL use little-endian lanes: byte k = bits [8k+7:8k], k = addr[1:0]; half = bits [31:16] if addr[1], else bits [15:0].
REQ-023 SHALL sign-extend for dmtype 001/011 and zero-extend for 010/100.
REQ-024 SHALL have these latencies from the handshake cycle to the first resp_valid cycle: load 3; word store 2; sub-word store 4; rejected request 1.
REQ-025 SHALL drive mem_en=0 outside RD and WR, and mem_we=0 outside WR.
REQ-026 SHALL leave unselected bytes of a merged word equal to the value read in CAP.

Reset
REQ-027 SHALL, while rstn=0, force state IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0 and mem_wdata=0; req_ready=1 once rstn=1.
REQ-028 SHALL, if reset is asserted mid-operation, abandon the request immediately with no RAM write and no response after release.

Configuration
REQ-029 SHALL, when DM_MISALIGN_TRAP_EN is defined, reject a half access with addr[0]=1 or a word access with addr[1:0]!=00: go to RESP, err=1, rdata=0, no RAM access.
REQ-030 SHALL, when DM_MISALIGN_TRAP_EN is undefined, ignore misaligned low bits (word uses lane 0, half uses addr[1] only); resp_err is then raised only for an illegal dmtype.

Verification
REQ-031 SHALL be verified by: RAM[1]=0x8081_F2A3, load dmtype=011, addr=0x5 -> resp_rdata=0xFFFF_FFF2, resp_valid 3 cycles after the handshake, exactly one mem_en read.
REQ-032 SHALL be verified by: the same RAM word, load dmtype=010, addr=0x6 -> resp_rdata=0x0000_8081.
REQ-033 SHALL be verified by: RAM[2]=0x1122_3344, store dmtype=011, addr=0xA, wdata=0xFFFF_FFAB -> RAM[2]=0x11AB_3344, one read then one write, response at +4 cycles with err=0.
REQ-034 SHALL be verified by: a word store of 0xDEAD_BEEF to addr 0x10 -> a single mem_we cycle at mem_addr=4, response at +2; resp_ready held 0 for 5 cycles -> resp_valid stays 1, req_ready stays 0.
REQ-035 SHALL be verified by: a word load at addr 0x3 -> err=1, no mem_en (macro defined); reads RAM[0] with err=0 (macro undefined); dmtype=110 -> err=1 in both builds.
REQ-036 SHALL be verified by: rstn pulsed low in the CAP cycle of a sub-word store -> no mem_we pulse, the RAM word is unchanged, and req_ready=1 with resp_valid=0 after release.

Source files
------------

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - data-memory load/store unit in front of a synchronous word RAM
//
// Purpose: accepts one load or store request at a time and runs it against a
// single-port synchronous word RAM. It returns extended load data, or an error
// for a rejected request. Sub-word stores are done as read-modify-write.
// Optional feature: define DM_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_dmtype          store flag and access type
//                               (000 w, 001 h, 010 hu, 011 b, 100 bu)
//   req_addr, req_wdata         byte address, right-aligned store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata, resp_err        extended load data (0 for stores/errors), reject flag
//   mem_en, mem_we, mem_addr    RAM strobe, write enable, word address
//   mem_wdata, mem_rdata        RAM write data, RAM read data (one cycle after a read)
module dm_lsu (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_dmtype,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t      state, state_d;
  logic        r_we;
  logic [2:0]  r_type;
  logic [31:0] r_addr;
  // Store data until CAP; for a sub-word store it then holds the merged word.
  logic [31:0] r_word;
  logic        req_bad;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;
  logic [31:0] merged;

  always_comb begin
    req_bad = (req_dmtype > 3'd4);
`ifdef DM_MISALIGN_TRAP_EN
    if (req_dmtype == 3'b000 && req_addr[1:0] != 2'b00) req_bad = 1'b1;
    if ((req_dmtype == 3'b001 || req_dmtype == 3'b010) && req_addr[0]) req_bad = 1'b1;
`endif
  end

  // Lane selection ignores misaligned low bits. A half access uses addr[1] only.
  // A word access always uses the whole word.
  always_comb begin
    byte_sel  = mem_rdata[{r_addr[1:0], 3'b000} +: 8];
    half_sel  = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data = 32'h0;
    case (r_type)
      3'b000:  load_data = mem_rdata;
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b010:  load_data = {16'h0, half_sel};
      3'b011:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      default: load_data = 32'h0;
    endcase
  end

  // The store lane replaces its bytes. All other bytes keep the value just read.
  always_comb begin
    merged = mem_rdata;
    case (r_type)
      3'b001, 3'b010: begin
        if (r_addr[1]) merged[31:16] = r_word[15:0];
        else           merged[15:0]  = r_word[15:0];
      end
      3'b011, 3'b100: merged[{r_addr[1:0], 3'b000} +: 8] = r_word[7:0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                              state_d = RESP;
          else if (req_we && req_dmtype == 3'b000)  state_d = WR;
          else                                      state_d = RD;
        end
      end
      RD: begin
        mem_en  = 1'b1;
        state_d = CAP;
      end
      CAP: state_d = r_we ? WR : RESP;
      WR: begin
        mem_en  = 1'b1;
        mem_we  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we       <= 1'b0;
      r_type     <= 3'b000;
      r_addr     <= 32'h0;
      r_word     <= 32'h0;
      resp_rdata <= 32'h0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_we       <= req_we;
          r_type     <= req_dmtype;
          r_addr     <= req_addr;
          r_word     <= req_wdata;
          resp_rdata <= 32'h0;
          resp_err   <= req_bad;
        end
        CAP: begin
          if (r_we) r_word     <= merged;
          else      resp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = r_addr[31:2];
  assign mem_wdata = mem_we ? r_word : 32'h0;

endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - directed scoreboard bench for dm_lsu with a behavioural word RAM
module tb_dm_lsu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_dmtype;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en, mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  dm_lsu dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_dmtype(req_dmtype), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:63];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [29:0] last_wr_addr = 30'h0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr[5:0]] <= mem_wdata;
        wr_cnt             <= wr_cnt + 1;
        last_wr_addr       <= mem_addr;
      end else begin
        mem_rdata <= ram[mem_addr[5:0]];
        rd_cnt    <= rd_cnt + 1;
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rds;
    int          wrs;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [2:0] t,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_rds, input int exp_wrs,
                        input int stall);
    exp_t e;
    int   cyc;
    int   rd0;
    int   wr0;
    logic [31:0] held;
    q.push_back('{exp_rd, exp_err, exp_lat, exp_rds, exp_wrs});
    @(negedge clk);
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid  = 1'b1;
    req_we     = we;
    req_dmtype = t;
    req_addr   = a;
    req_wdata  = wd;
    check({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!resp_valid && cyc < 20);
    e = q.pop_front();
    check({tag, ".latency"}, 32'(cyc), 32'(e.lat));
    check({tag, ".rdata"}, resp_rdata, e.rdata);
    check({tag, ".err"}, 32'(resp_err), 32'(e.err));
    held = resp_rdata;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, 32'(resp_valid), 32'd1);
      check({tag, ".stall_ready"}, 32'(req_ready), 32'd0);
      check({tag, ".stall_rdata"}, resp_rdata, held);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    check({tag, ".reads"}, 32'(rd_cnt - rd0), 32'(e.rds));
    check({tag, ".writes"}, 32'(wr_cnt - wr0), 32'(e.wrs));
    check({tag, ".idle_after"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int wr0;
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_dmtype = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'h0);
    check("rst.resp_err", 32'(resp_err), 32'd0);
    check("rst.mem_en", 32'(mem_en), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_addr", 32'(mem_addr), 32'h0);
    check("rst.mem_wdata", mem_wdata, 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("rst.req_ready", 32'(req_ready), 32'd1);

    // Preload through word stores.
    do_req("pre0", 1'b1, 3'b000, 32'h0, 32'hCAFE_BABE, 32'h0, 1'b0, 2, 0, 1, 0);
    check("pre0.ram", ram[0], 32'hCAFE_BABE);
    do_req("pre1", 1'b1, 3'b000, 32'h4, 32'h8081_F2A3, 32'h0, 1'b0, 2, 0, 1, 0);
    do_req("pre2", 1'b1, 3'b000, 32'h8, 32'h1122_3344, 32'h0, 1'b0, 2, 0, 1, 0);

    // Loads with every extension type.
    do_req("lb", 1'b0, 3'b011, 32'h5, 32'h0, 32'hFFFF_FFF2, 1'b0, 3, 1, 0, 0);
    do_req("lhu", 1'b0, 3'b010, 32'h6, 32'h0, 32'h0000_8081, 1'b0, 3, 1, 0, 0);
    do_req("lh", 1'b0, 3'b001, 32'h4, 32'h0, 32'hFFFF_F2A3, 1'b0, 3, 1, 0, 0);
    do_req("lbu", 1'b0, 3'b100, 32'h7, 32'h0, 32'h0000_0080, 1'b0, 3, 1, 0, 0);
    do_req("lw", 1'b0, 3'b000, 32'h4, 32'h0, 32'h8081_F2A3, 1'b0, 3, 1, 0, 0);

    // Sub-word stores (read-modify-write).
    do_req("sb", 1'b1, 3'b011, 32'hA, 32'hFFFF_FFAB, 32'h0, 1'b0, 4, 1, 1, 0);
    check("sb.ram", ram[2], 32'h11AB_3344);

    // Word store with a stalled response.
    do_req("sw", 1'b1, 3'b000, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 0, 1, 5);
    check("sw.ram", ram[4], 32'hDEAD_BEEF);
    check("sw.waddr", 32'(last_wr_addr), 32'd4);
    do_req("sh", 1'b1, 3'b010, 32'h12, 32'h0000_1234, 32'h0, 1'b0, 4, 1, 1, 0);
    check("sh.ram", ram[4], 32'h1234_BEEF);

`ifdef DM_MISALIGN_TRAP_EN
    do_req("lw_mis", 1'b0, 3'b000, 32'h3, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
`else
    do_req("lw_mis", 1'b0, 3'b000, 32'h3, 32'h0, 32'hCAFE_BABE, 1'b0, 3, 1, 0, 0);
`endif
    do_req("bad_type", 1'b0, 3'b110, 32'h4, 32'h0, 32'h0, 1'b1, 1, 0, 0, 0);
    do_req("bad_st", 1'b1, 3'b111, 32'h8, 32'h55, 32'h0, 1'b1, 1, 0, 0, 0);
    check("bad_st.ram", ram[2], 32'h11AB_3344);

    // Reset in the CAP cycle of a sub-word store.
    @(negedge clk);
    wr0 = wr_cnt;
    req_valid = 1'b1; req_we = 1'b1; req_dmtype = 3'b011;
    req_addr = 32'h8; req_wdata = 32'h55;
    @(posedge clk);          // handshake
    #1 req_valid = 1'b0;
    @(posedge clk);          // RD -> CAP
    #1 rstn = 1'b0;
    @(negedge clk);
    check("midrst.mem_we", 32'(mem_we), 32'd0);
    check("midrst.resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("midrst.req_ready", 32'(req_ready), 32'd1);
      check("midrst.no_resp", 32'(resp_valid), 32'd0);
    end
    check("midrst.writes", 32'(wr_cnt - wr0), 32'd0);
    check("midrst.ram", ram[2], 32'h11AB_3344);

    // Normal operation resumes after the abandoned request.
    do_req("post", 1'b0, 3'b100, 32'h9, 32'h0, 32'h0000_0033, 1'b0, 3, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
